icache_assoc: RTL



---
 rtl/icache_assoc_if.sv | 34 +++
 rtl/icache_assoc.sv | 135 +++++++++++++
 2 files changed

// File: rtl/icache_assoc_if.sv
// Fetch/refill port bundle of the set-associative instruction cache.
// The core/refill side uses the master modport; the cache uses the slave modport.
interface icache_assoc_if #(
  parameter int unsigned tag_width_p           = 10,
  parameter int unsigned sets_p                = 64,
  parameter int unsigned ways_p                = 2,
  parameter int unsigned block_size_in_words_p = 4,
  parameter int unsigned instr_width_p         = 32
);
  localparam int unsigned pc_width_lp =
    tag_width_p + $clog2(sets_p) + $clog2(block_size_in_words_p);

  logic                     v_i;
  logic                     w_i;
  logic                     flush_i;
  logic [pc_width_lp-1:0]   w_pc_i;
  logic [instr_width_p-1:0] w_instr_i;
  logic [pc_width_lp-1:0]   pc_i;
  logic [instr_width_p-1:0] instr_o;
  logic [pc_width_lp-1:0]   pc_r_o;
  logic                     icache_miss_o;
  logic [ways_p-1:0]        hit_way_o;
  logic                     refill_err_o;

  modport master (
    output v_i, w_i, flush_i, w_pc_i, w_instr_i, pc_i,
    input  instr_o, pc_r_o, icache_miss_o, hit_way_o, refill_err_o
  );

  modport slave (
    input  v_i, w_i, flush_i, w_pc_i, w_instr_i, pc_i,
    output instr_o, pc_r_o, icache_miss_o, hit_way_o, refill_err_o
  );
endinterface

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache: 1-cycle fetch read, word-sequential
// block refill with order checking, per-set round-robin victims, one-cycle flush.
module icache_assoc #(
  parameter int unsigned tag_width_p           = 10,
  parameter int unsigned sets_p                = 64,
  parameter int unsigned ways_p                = 2,
  parameter int unsigned block_size_in_words_p = 4,
  parameter int unsigned instr_width_p         = 32
) (
  input  logic           clk_i,
  input  logic           reset_n_i,
  icache_assoc_if.slave  bus
);
  localparam int unsigned set_bits_lp = $clog2(sets_p);
  localparam int unsigned off_bits_lp = $clog2(block_size_in_words_p);
  localparam int unsigned way_bits_lp = (ways_p > 1) ? $clog2(ways_p) : 1;
  localparam int unsigned pc_width_lp = tag_width_p + set_bits_lp + off_bits_lp;
  localparam int unsigned words_lp    = block_size_in_words_p;

  typedef struct packed {
    logic [tag_width_p-1:0]                  tag;
    logic [words_lp-1:0][instr_width_p-1:0]  data;
  } line_t;

  logic [pc_width_lp-1:0]   pc_r;
  logic [ways_p-1:0]        vld_r;
  logic [off_bits_lp-1:0]   write_count_r;
  logic                     refill_err_r;
  logic [ways_p-1:0]        valid_r [sets_p];
  logic [way_bits_lp-1:0]   rr_r    [sets_p];
  logic [instr_width_p-1:0] buf_r   [words_lp];
  line_t                    mem_r   [ways_p][sets_p];
  line_t                    rd_r    [ways_p];

  logic                     rd_en, wr_en, wr_ok, wr_last;
  logic [tag_width_p-1:0]   w_tag, r_tag;
  logic [set_bits_lp-1:0]   w_set, r_set;
  logic [off_bits_lp-1:0]   w_off, r_off;
  logic [way_bits_lp-1:0]   victim, victim_next;
  line_t                    wr_line;
  logic [ways_p-1:0]        hit;
  logic [instr_width_p-1:0] instr;

  // Refill has priority over fetch when both are requested.
  assign rd_en   = bus.v_i & ~bus.w_i;
  assign wr_en   = bus.v_i &  bus.w_i;
  assign w_tag   = bus.w_pc_i[pc_width_lp-1 -: tag_width_p];
  assign w_set   = bus.w_pc_i[off_bits_lp +: set_bits_lp];
  assign w_off   = bus.w_pc_i[off_bits_lp-1:0];
  assign r_set   = bus.pc_i[off_bits_lp +: set_bits_lp];
  assign r_tag   = pc_r[pc_width_lp-1 -: tag_width_p];
  assign r_off   = pc_r[off_bits_lp-1:0];
  assign wr_ok   = wr_en & (w_off == write_count_r);
  assign wr_last = wr_ok & (w_off == off_bits_lp'(words_lp - 1));
  assign victim  = rr_r[w_set];
  assign victim_next = (victim == way_bits_lp'(ways_p - 1)) ? '0 : victim + 1'b1;

  // NOTE: every clocked assignment uses <= so all flops sample pre-edge values
  // regardless of statement order; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pc_r          <= '0;
      vld_r         <= '0;
      write_count_r <= '0;
      refill_err_r  <= 1'b0;
      for (int s = 0; s < int'(sets_p); s++) begin
        valid_r[s] <= '0;
        rr_r[s]    <= '0;
      end
    end else begin
      refill_err_r <= wr_en & ~wr_ok;
      if (rd_en) begin
        pc_r  <= bus.pc_i;
        vld_r <= valid_r[r_set];
      end
      // Flush overrides any refill bookkeeping in the same cycle.
      if (bus.flush_i) begin
        write_count_r <= '0;
        for (int s = 0; s < int'(sets_p); s++) begin
          valid_r[s] <= '0;
          rr_r[s]    <= '0;
        end
      end else if (wr_en) begin
        if (!wr_ok) begin
          write_count_r <= '0;
        end else if (wr_last) begin
          write_count_r          <= '0;
          valid_r[w_set][victim] <= 1'b1;
          rr_r[w_set]            <= victim_next;
        end else begin
          write_count_r <= write_count_r + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok && !wr_last) buf_r[w_off] <= bus.w_instr_i;
  end

  // NOTE: the tag/data RAMs and their read latches are deliberately not reset;
  // SRAM macros have no reset, and the valid flops alone make stale contents harmless.
  always_ff @(posedge clk_i) begin
    if (rd_en) begin
      for (int i = 0; i < int'(ways_p); i++) rd_r[i] <= mem_r[i][r_set];
    end
    if (wr_last) mem_r[victim][w_set] <= wr_line;
  end

  always_comb begin
    wr_line.tag = w_tag;
    for (int k = 0; k < int'(words_lp) - 1; k++) wr_line.data[k] = buf_r[k];
    wr_line.data[words_lp-1] = bus.w_instr_i;
  end

  // NOTE: hit and instr get defaults before the loop so every path assigns
  // them and no latch is inferred.
  always_comb begin
    hit   = '0;
    instr = '0;
    // Descending scan leaves the lowest-index hitting way's word in instr.
    for (int i = int'(ways_p) - 1; i >= 0; i--) begin
      if (vld_r[i] && (rd_r[i].tag == r_tag)) begin
        hit[i] = 1'b1;
        instr  = rd_r[i].data[r_off];
      end
    end
  end

  assign bus.instr_o       = instr;
  assign bus.pc_r_o        = pc_r;
  assign bus.icache_miss_o = ~|hit;
  assign bus.hit_way_o     = hit;
  assign bus.refill_err_o  = refill_err_r;
endmodule
